alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- ALU reservation station: the receiving end of the result broadcast buses and the producer of the alu_cdb_t bus.
- Accepts dispatched ALU operations from the decode/dispatch stage with operand values or producer ROB tags.
- Snoops all functional-unit broadcasts (ALU, CMP, LD/ST, JALR) to capture pending operands.
- Each entry owns one ALU; when both operands are present it computes and broadcasts on its alu_cdb_t lane.

Parameters:
- N_ENTRIES, ooo_types::NUM_ALU_RS (5), number of entries and alu_cdb_t lanes; must equal NUM_ALU_RS.
- TAG_NONE, 4'd0, tag value meaning "operand already valid / no producer"; valid ROB tags are 1..ROB_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous squash of all entries (mispredict recovery)
- disp_valid  in  1  dispatch request this cycle
- disp_op  in  alu_ops  ALU operation (rv32i_types)
- disp_tag  in  tag_t  destination ROB tag
- disp_vj, disp_vk  in  32 each  operand values, meaningful when the matching Q is TAG_NONE
- disp_qj, disp_qk  in  tag_t each  producer tags; TAG_NONE = value valid
- rs_full  out  1  no free entry (combinational from registered state)
- alu_cdb_in  in  alu_cdb_t  snooped ALU broadcasts, including this block's own registered output
- cmp_cdb_in  in  cmp_cdb_t  snooped CMP broadcasts
- mem_cdb_in  in  mem_cdb_t  snooped LD/ST broadcasts; only loads' val is meaningful
- jalr_cdb_in  in  jalr_cdb_t  snooped JALR broadcast
- alu_cdb_out  out  alu_cdb_t  registered result broadcast, one lane per entry

Behaviour:
- Entry state: busy, op, tag, vj, qj, vk, qk.
- Reset or flush: all busy=0, qj/qk=TAG_NONE, alu_cdb_out.valid[*]=0, tags=0, vals=0. Flush overrides dispatch and broadcast in the same cycle.
- rs_full = all busy.
- Dispatch is accepted when disp_valid && !rs_full. The lowest-index non-busy entry, judged on registered state, is written.
  - disp_valid while rs_full is ignored; the dispatcher must hold.
  - An entry freed at edge E is reusable for dispatch only after E.
- Snoop: on every edge, each busy entry with qj != TAG_NONE compares qj against every valid lane of all four buses.
  - On a match, vj takes that lane's val and qj becomes TAG_NONE. qk is handled the same way.
  - Multiple matches on the same tag cannot occur by ROB invariant; priority is ALU lanes low→high, then CMP, MEM, JALR.
- Dispatch forwarding: disp_qj/disp_qk are compared against the same-cycle buses. On a match the entry is written with the value and TAG_NONE, so no broadcast is missed.
- Execute: an entry is "ready" when busy && qj==qk==TAG_NONE, evaluated on registered state. On the next edge:
  - alu_cdb_out.valid[i]<=1, tags[i]<=tag, vals[i]<=ALU(op,vj,vk)
  - busy[i]<=0
- Otherwise valid[i]<=0 each cycle, so valid is a one-cycle pulse. tags/vals hold their last value.
- Latency: dispatch with both operands ready at edge E0 → broadcast visible after E1 (1 cycle in RS).
  - Operand captured from a CDB at E0 → broadcast after E1.
- Arithmetic is 32-bit and wraps.
  - sra: arithmetic shift right; sll/srl: logical shift by vk[4:0].
  - add/sub/xor/or/and: standard.
- All entries may broadcast in the same cycle; lanes are independent.

Optional Feature:
- Macro ALU_RS_PERF_EN.
- Defined: adds outputs perf_issued (32-bit, counts broadcasts) and perf_full_stall (32-bit, counts cycles with disp_valid && rs_full). Both saturate at 32'hFFFF_FFFF and clear on rst; flush does not clear them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- ooo_types gains rs_entry_t (packed: busy, op, tag, vj, qj, vk, qk) and TAG_NONE.
- A natural sub-module is cdb_snoop: combinational tag-match over all buses, returning hit and value. It is instanced twice per entry plus twice for dispatch forwarding.

Test Plan:
- rst high 2 cycles → all alu_cdb_out.valid=0, rs_full=0. Dispatch add tag=3, vj=5, vk=7, qj=qk=0 → lane0 valid one cycle after, tag=3, val=12.
- Dispatch sub tag=2, qj=4, vk=1; two cycles later mem_cdb_in lane1 valid, tag=4, val=10 → next cycle lane0 val=9, tag=2.
- Dispatch with disp_qk=5 in the same cycle cmp_cdb_in lane0 carries tag=5, val=1 → forwarded; broadcast after 1 cycle with vk=1.
- Fill 5 entries all waiting on tag 6 → rs_full=1, 6th dispatch ignored. jalr_cdb_in tag=6 → all 5 lanes valid the same cycle, then rs_full=0.
- sra vj=32'h8000_0000, vk=32'h21 → 32'hC000_0000. sll vj=1, vk=31 → 32'h8000_0000. add 32'hFFFF_FFFF+1 → 0.
- flush asserted with 3 busy entries plus concurrent dispatch → next cycle no busy entries, no broadcasts, rs_full=0.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: tags, ALU opcodes, result buses, entry record.
// Valid ROB tags are 1..15; tag 0 means "operand already present".
// Build option ALU_RS_PERF_EN (see alu_rs.sv) adds no types here.
package alu_rs_pkg;

    localparam int NUM_ALU_RS     = 5;
    localparam int NUM_CMP_LANES  = 2;
    localparam int NUM_MEM_LANES  = 2;
    localparam int NUM_JALR_LANES = 1;

    typedef logic [3:0] tag_t;
    localparam tag_t TAG_NONE = 4'd0;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef struct packed {
        logic [NUM_ALU_RS-1:0]        valid;
        tag_t [NUM_ALU_RS-1:0]        tags;
        logic [NUM_ALU_RS-1:0][31:0]  vals;
    } alu_cdb_t;

    typedef struct packed {
        logic [NUM_CMP_LANES-1:0]       valid;
        tag_t [NUM_CMP_LANES-1:0]       tags;
        logic [NUM_CMP_LANES-1:0][31:0] vals;
    } cmp_cdb_t;

    // Store broadcasts may appear here too; no consumer ever waits on a store tag.
    typedef struct packed {
        logic [NUM_MEM_LANES-1:0]       valid;
        tag_t [NUM_MEM_LANES-1:0]       tags;
        logic [NUM_MEM_LANES-1:0][31:0] vals;
    } mem_cdb_t;

    typedef struct packed {
        logic [NUM_JALR_LANES-1:0]       valid;
        tag_t [NUM_JALR_LANES-1:0]       tags;
        logic [NUM_JALR_LANES-1:0][31:0] vals;
    } jalr_cdb_t;

    typedef struct packed {
        logic        busy;
        alu_ops      op;
        tag_t        tag;
        logic [31:0] vj;
        tag_t        qj;
        logic [31:0] vk;
        tag_t        qk;
    } rs_entry_t;

    function automatic logic [31:0] alu_exec(alu_ops op, logic [31:0] a, logic [31:0] b);
        logic [31:0] res;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            alu_add: res = a + b;
            alu_sll: res = a << sh;
            alu_sra: res = $unsigned($signed(a) >>> sh);
            alu_sub: res = a - b;
            alu_xor: res = a ^ b;
            alu_srl: res = a >> sh;
            alu_or:  res = a | b;
            alu_and: res = a & b;
            default: res = a + b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, snoop and result-broadcast bundle between the RS and its surroundings.
// master = dispatcher/bus side, slave = reservation station.
// rs_full is the only backpressure: the dispatcher holds while it is high.
interface alu_rs_if;
    import alu_rs_pkg::*;

    logic        flush;
    logic        disp_valid;
    alu_ops      disp_op;
    tag_t        disp_tag;
    logic [31:0] disp_vj;
    logic [31:0] disp_vk;
    tag_t        disp_qj;
    tag_t        disp_qk;
    logic        rs_full;

    alu_cdb_t    alu_cdb_in;
    cmp_cdb_t    cmp_cdb_in;
    mem_cdb_t    mem_cdb_in;
    jalr_cdb_t   jalr_cdb_in;
    alu_cdb_t    alu_cdb_out;

    modport master (
        output flush, disp_valid, disp_op, disp_tag, disp_vj, disp_vk, disp_qj, disp_qk,
        output alu_cdb_in, cmp_cdb_in, mem_cdb_in, jalr_cdb_in,
        input  rs_full, alu_cdb_out
    );

    modport slave (
        input  flush, disp_valid, disp_op, disp_tag, disp_vj, disp_vk, disp_qj, disp_qk,
        input  alu_cdb_in, cmp_cdb_in, mem_cdb_in, jalr_cdb_in,
        output rs_full, alu_cdb_out
    );
endinterface

// File: rtl/alu_rs_cdb_snoop.sv
// Tag match of one pending operand against every valid lane of all result buses.
// Latency: combinational. Backpressure: none.
// Priority on multiple hits: ALU lanes low->high, then CMP, MEM, JALR.
module alu_rs_cdb_snoop
    import alu_rs_pkg::*;
(
    input  tag_t        q,
    input  alu_cdb_t    alu_cdb,
    input  cmp_cdb_t    cmp_cdb,
    input  mem_cdb_t    mem_cdb,
    input  jalr_cdb_t   jalr_cdb,
    output logic        hit,
    output logic [31:0] val
);

    always_comb begin
        hit = 1'b0;
        val = '0;
        if (q != TAG_NONE) begin
            for (int i = 0; i < NUM_ALU_RS; i++) begin
                if (!hit && alu_cdb.valid[i] && alu_cdb.tags[i] == q) begin
                    hit = 1'b1;
                    val = alu_cdb.vals[i];
                end
            end
            for (int i = 0; i < NUM_CMP_LANES; i++) begin
                if (!hit && cmp_cdb.valid[i] && cmp_cdb.tags[i] == q) begin
                    hit = 1'b1;
                    val = cmp_cdb.vals[i];
                end
            end
            for (int i = 0; i < NUM_MEM_LANES; i++) begin
                if (!hit && mem_cdb.valid[i] && mem_cdb.tags[i] == q) begin
                    hit = 1'b1;
                    val = mem_cdb.vals[i];
                end
            end
            for (int i = 0; i < NUM_JALR_LANES; i++) begin
                if (!hit && jalr_cdb.valid[i] && jalr_cdb.tags[i] == q) begin
                    hit = 1'b1;
                    val = jalr_cdb.vals[i];
                end
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, snoops result buses, executes and broadcasts per entry.
// Latency: ready at edge E0 -> registered broadcast after E1; optional counters under ALU_RS_PERF_EN.
// Backpressure: rs_full (all entries busy); dispatch while full is dropped and must be held upstream.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int N_ENTRIES = NUM_ALU_RS  // one entry per alu_cdb_t lane; must equal NUM_ALU_RS
)(
    input  logic        clk,
    input  logic        rst,
    alu_rs_if.slave     rs_if
`ifdef ALU_RS_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_full_stall
`endif
);

    rs_entry_t            ent_q [N_ENTRIES];
    rs_entry_t            ent_d [N_ENTRIES];
    logic [N_ENTRIES-1:0] busy;
    logic [N_ENTRIES-1:0] ready;
    logic [N_ENTRIES-1:0] alloc_oh;
    logic [N_ENTRIES-1:0] hit_j;
    logic [N_ENTRIES-1:0] hit_k;
    logic [31:0]          snp_vj [N_ENTRIES];
    logic [31:0]          snp_vk [N_ENTRIES];
    logic                 dhit_j;
    logic                 dhit_k;
    logic [31:0]          dval_j;
    logic [31:0]          dval_k;
    logic                 disp_fire;
    alu_cdb_t             cdb_q;

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_snoop
        alu_rs_cdb_snoop u_snoop_j (
            .q        (ent_q[g].qj),
            .alu_cdb  (rs_if.alu_cdb_in),
            .cmp_cdb  (rs_if.cmp_cdb_in),
            .mem_cdb  (rs_if.mem_cdb_in),
            .jalr_cdb (rs_if.jalr_cdb_in),
            .hit      (hit_j[g]),
            .val      (snp_vj[g])
        );
        alu_rs_cdb_snoop u_snoop_k (
            .q        (ent_q[g].qk),
            .alu_cdb  (rs_if.alu_cdb_in),
            .cmp_cdb  (rs_if.cmp_cdb_in),
            .mem_cdb  (rs_if.mem_cdb_in),
            .jalr_cdb (rs_if.jalr_cdb_in),
            .hit      (hit_k[g]),
            .val      (snp_vk[g])
        );
    end

    // Forwarding for the incoming op so a broadcast in the dispatch cycle is not lost.
    alu_rs_cdb_snoop u_disp_snoop_j (
        .q        (rs_if.disp_qj),
        .alu_cdb  (rs_if.alu_cdb_in),
        .cmp_cdb  (rs_if.cmp_cdb_in),
        .mem_cdb  (rs_if.mem_cdb_in),
        .jalr_cdb (rs_if.jalr_cdb_in),
        .hit      (dhit_j),
        .val      (dval_j)
    );
    alu_rs_cdb_snoop u_disp_snoop_k (
        .q        (rs_if.disp_qk),
        .alu_cdb  (rs_if.alu_cdb_in),
        .cmp_cdb  (rs_if.cmp_cdb_in),
        .mem_cdb  (rs_if.mem_cdb_in),
        .jalr_cdb (rs_if.jalr_cdb_in),
        .hit      (dhit_k),
        .val      (dval_k)
    );

    always_comb begin
        logic found;
        found    = 1'b0;
        busy     = '0;
        ready    = '0;
        alloc_oh = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            busy[i]     = ent_q[i].busy;
            ready[i]    = ent_q[i].busy && ent_q[i].qj == TAG_NONE && ent_q[i].qk == TAG_NONE;
            alloc_oh[i] = !ent_q[i].busy && !found;
            if (!ent_q[i].busy) begin
                found = 1'b1;
            end
        end
    end

    assign rs_if.rs_full     = &busy;
    assign disp_fire         = rs_if.disp_valid && !rs_if.rs_full;
    assign rs_if.alu_cdb_out = cdb_q;

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (ready[i]) begin
                ent_d[i].busy = 1'b0;
            end else if (ent_q[i].busy) begin
                if (hit_j[i]) begin
                    ent_d[i].vj = snp_vj[i];
                    ent_d[i].qj = TAG_NONE;
                end
                if (hit_k[i]) begin
                    ent_d[i].vk = snp_vk[i];
                    ent_d[i].qk = TAG_NONE;
                end
            end
            // The allocated slot is never busy, so this never collides with the updates above.
            if (disp_fire && alloc_oh[i]) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].op   = rs_if.disp_op;
                ent_d[i].tag  = rs_if.disp_tag;
                ent_d[i].vj   = dhit_j ? dval_j : rs_if.disp_vj;
                ent_d[i].qj   = dhit_j ? TAG_NONE : rs_if.disp_qj;
                ent_d[i].vk   = dhit_k ? dval_k : rs_if.disp_vk;
                ent_d[i].qk   = dhit_k ? TAG_NONE : rs_if.disp_qk;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rs_if.flush) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            cdb_q <= '0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
                if (ready[i]) begin
                    cdb_q.tags[i] <= ent_q[i].tag;
                    cdb_q.vals[i] <= alu_exec(ent_q[i].op, ent_q[i].vj, ent_q[i].vk);
                end
            end
            cdb_q.valid <= ready;
        end
    end

`ifdef ALU_RS_PERF_EN
    localparam int CNT_W = $clog2(N_ENTRIES + 1);

    logic [CNT_W-1:0] issue_cnt;
    logic [32:0]      issued_sum;

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            issue_cnt = issue_cnt + CNT_W'(ready[i]);
        end
    end

    assign issued_sum = {1'b0, perf_issued} + 33'(issue_cnt);

    // Counters survive flush; squashed ready entries never broadcast, so they are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued     <= '0;
            perf_full_stall <= '0;
        end else begin
            if (!rs_if.flush) begin
                perf_issued <= issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
            end
            if (rs_if.disp_valid && rs_if.rs_full && perf_full_stall != 32'hFFFF_FFFF) begin
                perf_full_stall <= perf_full_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios then random traffic, checked every cycle against a slot-level model.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_rs_if bif ();

`ifdef ALU_RS_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_full_stall;
`endif

    alu_rs dut (
        .clk   (clk),
        .rst   (rst),
        .rs_if (bif.slave)
`ifdef ALU_RS_PERF_EN
        ,
        .perf_issued     (perf_issued),
        .perf_full_stall (perf_full_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Model: a pending op waits on producer tags wa/wb (0 = have value).
    typedef struct {
        bit          live;
        alu_ops      op;
        logic [3:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  wa;
        logic [3:0]  wb;
    } op_t;

    op_t         slot    [NUM_ALU_RS];
    logic [NUM_ALU_RS-1:0] exp_vld;
    logic [3:0]  exp_tag [NUM_ALU_RS];
    logic [31:0] exp_val [NUM_ALU_RS];
    longint      m_issued = 0;
    longint      m_stall  = 0;

    function automatic logic [31:0] ref_alu(alu_ops op, logic [31:0] a, logic [31:0] b);
        int          sh;
        logic [63:0] ext;
        sh  = int'(b % 32);
        ext = {{32{a[31]}}, a};
        case (op)
            alu_add: return a + b;
            alu_sub: return a + (~b) + 32'd1;
            alu_sll: return a * (32'd1 << sh);
            alu_srl: return a / (32'd1 << sh);
            alu_sra: begin ext = ext >> sh; return ext[31:0]; end
            alu_xor: return a ^ b;
            alu_or:  return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit bus_lookup(logic [3:0] t, output logic [31:0] v);
        v = '0;
        if (t == 4'd0) return 1'b0;
        for (int i = 0; i < NUM_ALU_RS; i++)
            if (bif.alu_cdb_in.valid[i] && bif.alu_cdb_in.tags[i] == t) begin v = bif.alu_cdb_in.vals[i]; return 1'b1; end
        for (int i = 0; i < NUM_CMP_LANES; i++)
            if (bif.cmp_cdb_in.valid[i] && bif.cmp_cdb_in.tags[i] == t) begin v = bif.cmp_cdb_in.vals[i]; return 1'b1; end
        for (int i = 0; i < NUM_MEM_LANES; i++)
            if (bif.mem_cdb_in.valid[i] && bif.mem_cdb_in.tags[i] == t) begin v = bif.mem_cdb_in.vals[i]; return 1'b1; end
        for (int i = 0; i < NUM_JALR_LANES; i++)
            if (bif.jalr_cdb_in.valid[i] && bif.jalr_cdb_in.tags[i] == t) begin v = bif.jalr_cdb_in.vals[i]; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_step();
        bit          full;
        int          free_idx;
        logic [31:0] v;
        full     = 1'b1;
        free_idx = -1;
        for (int i = 0; i < NUM_ALU_RS; i++)
            if (!slot[i].live) begin
                full = 1'b0;
                if (free_idx < 0) free_idx = i;
            end
        if (rst) begin
            m_issued = 0;
            m_stall  = 0;
        end else if (bif.disp_valid && full) begin
            m_stall++;
        end
        if (rst || bif.flush) begin
            for (int i = 0; i < NUM_ALU_RS; i++) begin
                slot[i].live = 1'b0;
                exp_tag[i]   = '0;
                exp_val[i]   = '0;
            end
            exp_vld = '0;
            return;
        end
        for (int i = 0; i < NUM_ALU_RS; i++) begin
            exp_vld[i] = 1'b0;
            if (slot[i].live && slot[i].wa == 0 && slot[i].wb == 0) begin
                exp_vld[i]   = 1'b1;
                exp_tag[i]   = slot[i].dst;
                exp_val[i]   = ref_alu(slot[i].op, slot[i].a, slot[i].b);
                slot[i].live = 1'b0;
                m_issued++;
            end else if (slot[i].live) begin
                if (bus_lookup(slot[i].wa, v)) begin slot[i].a = v; slot[i].wa = 0; end
                if (bus_lookup(slot[i].wb, v)) begin slot[i].b = v; slot[i].wb = 0; end
            end
        end
        if (bif.disp_valid && !full) begin
            slot[free_idx].live = 1'b1;
            slot[free_idx].op   = bif.disp_op;
            slot[free_idx].dst  = bif.disp_tag;
            if (bus_lookup(bif.disp_qj, v)) begin slot[free_idx].a = v; slot[free_idx].wa = 0; end
            else begin slot[free_idx].a = bif.disp_vj; slot[free_idx].wa = bif.disp_qj; end
            if (bus_lookup(bif.disp_qk, v)) begin slot[free_idx].b = v; slot[free_idx].wb = 0; end
            else begin slot[free_idx].b = bif.disp_vk; slot[free_idx].wb = bif.disp_qk; end
        end
    endtask

    task automatic compare_all();
        bit exp_full;
        exp_full = 1'b1;
        for (int i = 0; i < NUM_ALU_RS; i++) if (!slot[i].live) exp_full = 1'b0;
        chk("rs_full", 32'(bif.rs_full), 32'(exp_full));
        for (int i = 0; i < NUM_ALU_RS; i++) begin
            chk($sformatf("vld%0d", i), 32'(bif.alu_cdb_out.valid[i]), 32'(exp_vld[i]));
            chk($sformatf("tag%0d", i), 32'(bif.alu_cdb_out.tags[i]), 32'(exp_tag[i]));
            chk($sformatf("val%0d", i), bif.alu_cdb_out.vals[i], exp_val[i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bif.flush           = 1'b0;
        bif.disp_valid      = 1'b0;
        bif.disp_op         = alu_add;
        bif.disp_tag        = '0;
        bif.disp_vj         = '0;
        bif.disp_vk         = '0;
        bif.disp_qj         = '0;
        bif.disp_qk         = '0;
        bif.alu_cdb_in      = '0;
        bif.cmp_cdb_in      = '0;
        bif.mem_cdb_in      = '0;
        bif.jalr_cdb_in     = '0;
    endtask

    task automatic disp(alu_ops op, logic [3:0] tag, logic [31:0] vj, logic [3:0] qj,
                        logic [31:0] vk, logic [3:0] qk);
        bif.disp_valid = 1'b1;
        bif.disp_op    = op;
        bif.disp_tag   = tag;
        bif.disp_vj    = vj;
        bif.disp_qj    = qj;
        bif.disp_vk    = vk;
        bif.disp_qk    = qk;
    endtask

    task automatic run_one(string name, alu_ops op, logic [31:0] vj, logic [31:0] vk, logic [31:0] exp);
        disp(op, 4'd1, vj, 4'd0, vk, 4'd0);
        cycle();
        idle_inputs();
        cycle();
        chk({name, "_vld"}, 32'(bif.alu_cdb_out.valid[0]), 32'd1);
        chk(name, bif.alu_cdb_out.vals[0], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_ALU_RS; i++) begin
            slot[i].live = 1'b0;
            exp_tag[i]   = '0;
            exp_val[i]   = '0;
        end
        exp_vld = '0;
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_full", 32'(bif.rs_full), 32'd0);
        chk("reset_vld", 32'(bif.alu_cdb_out.valid), 32'd0);

        // add with both operands ready: broadcast exactly one edge after the dispatch edge
        disp(alu_add, 4'd3, 32'd5, 4'd0, 32'd7, 4'd0);
        cycle();
        idle_inputs();
        chk("add_not_early", 32'(bif.alu_cdb_out.valid[0]), 32'd0);
        cycle();
        chk("add_vld", 32'(bif.alu_cdb_out.valid[0]), 32'd1);
        chk("add_tag", 32'(bif.alu_cdb_out.tags[0]), 32'd3);
        chk("add_val", bif.alu_cdb_out.vals[0], 32'd12);
        cycle();
        chk("add_pulse", 32'(bif.alu_cdb_out.valid[0]), 32'd0);

        // sub waiting on a load result
        disp(alu_sub, 4'd2, 32'd0, 4'd4, 32'd1, 4'd0);
        cycle();
        idle_inputs();
        cycle();
        bif.mem_cdb_in.valid[1] = 1'b1;
        bif.mem_cdb_in.tags[1]  = 4'd4;
        bif.mem_cdb_in.vals[1]  = 32'd10;
        cycle();
        idle_inputs();
        cycle();
        chk("sub_tag", 32'(bif.alu_cdb_out.tags[0]), 32'd2);
        chk("sub_val", bif.alu_cdb_out.vals[0], 32'd9);

        // operand forwarded from a same-cycle CMP broadcast
        disp(alu_add, 4'd7, 32'd41, 4'd0, 32'd0, 4'd5);
        bif.cmp_cdb_in.valid[0] = 1'b1;
        bif.cmp_cdb_in.tags[0]  = 4'd5;
        bif.cmp_cdb_in.vals[0]  = 32'd1;
        cycle();
        idle_inputs();
        cycle();
        chk("fwd_vld", 32'(bif.alu_cdb_out.valid[0]), 32'd1);
        chk("fwd_val", bif.alu_cdb_out.vals[0], 32'd42);

        // fill all entries on tag 6, overflow dispatch dropped, then release together
        for (int i = 0; i < NUM_ALU_RS; i++) begin
            disp(alu_add, 4'(8 + i), 32'd0, 4'd6, 32'(i), 4'd0);
            cycle();
        end
        chk("fill_full", 32'(bif.rs_full), 32'd1);
        disp(alu_add, 4'd14, 32'd1, 4'd0, 32'd1, 4'd0);
        cycle();
        idle_inputs();
        chk("drop_full", 32'(bif.rs_full), 32'd1);
        bif.jalr_cdb_in.valid[0] = 1'b1;
        bif.jalr_cdb_in.tags[0]  = 4'd6;
        bif.jalr_cdb_in.vals[0]  = 32'd100;
        cycle();
        idle_inputs();
        cycle();
        chk("all_lanes", 32'(bif.alu_cdb_out.valid), 32'h1F);
        chk("lane4_val", bif.alu_cdb_out.vals[4], 32'd104);
        chk("release_full", 32'(bif.rs_full), 32'd0);
        cycle();

        run_one("sra", alu_sra, 32'h8000_0000, 32'h21, 32'hC000_0000);
        run_one("sll", alu_sll, 32'd1, 32'd31, 32'h8000_0000);
        run_one("add_wrap", alu_add, 32'hFFFF_FFFF, 32'd1, 32'd0);

        // flush with three waiting entries and a concurrent dispatch
        for (int i = 0; i < 3; i++) begin
            disp(alu_or, 4'(1 + i), 32'd0, 4'd13, 32'd0, 4'd0);
            cycle();
        end
        disp(alu_and, 4'd9, 32'd3, 4'd0, 32'd1, 4'd0);
        bif.flush = 1'b1;
        bif.jalr_cdb_in.valid[0] = 1'b1;
        bif.jalr_cdb_in.tags[0]  = 4'd13;
        cycle();
        idle_inputs();
        chk("flush_full", 32'(bif.rs_full), 32'd0);
        chk("flush_vld", 32'(bif.alu_cdb_out.valid), 32'd0);
        cycle();
        chk("flush_quiet", 32'(bif.alu_cdb_out.valid), 32'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            bif.flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1)
                disp(alu_ops'($urandom_range(0, 7)), 4'($urandom_range(1, 15)), $urandom,
                     ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15)), $urandom,
                     ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15)));
            for (int i = 0; i < NUM_ALU_RS; i++) begin
                bif.alu_cdb_in.valid[i] = ($urandom_range(0, 3) == 0);
                bif.alu_cdb_in.tags[i]  = 4'($urandom_range(1, 15));
                bif.alu_cdb_in.vals[i]  = $urandom;
            end
            for (int i = 0; i < NUM_CMP_LANES; i++) begin
                bif.cmp_cdb_in.valid[i] = ($urandom_range(0, 3) == 0);
                bif.cmp_cdb_in.tags[i]  = 4'($urandom_range(1, 15));
                bif.cmp_cdb_in.vals[i]  = $urandom;
            end
            for (int i = 0; i < NUM_MEM_LANES; i++) begin
                bif.mem_cdb_in.valid[i] = ($urandom_range(0, 3) == 0);
                bif.mem_cdb_in.tags[i]  = 4'($urandom_range(1, 15));
                bif.mem_cdb_in.vals[i]  = $urandom;
            end
            bif.jalr_cdb_in.valid[0] = ($urandom_range(0, 3) == 0);
            bif.jalr_cdb_in.tags[0]  = 4'($urandom_range(1, 15));
            bif.jalr_cdb_in.vals[0]  = $urandom;
            cycle();
        end

`ifdef ALU_RS_PERF_EN
        chk("perf_issued", perf_issued, 32'(m_issued));
        chk("perf_full_stall", perf_full_stall, 32'(m_stall));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
